// File: rtl/ram_fifo_controller_if.sv
// Handshake bundle between a FIFO user and ram_fifo_controller.
// The master drives requests and data; the slave returns data, flags and occupancy.
interface ram_fifo_controller_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  sync_clear;
   logic                  write_req;
   logic [DATA_WIDTH-1:0] din;
   logic                  read_req;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output sync_clear, write_req, din, read_req,
      input  dout, dout_valid, empty, full, almost_full, count, overflow, underflow
   );

   modport slave (
      input  sync_clear, write_req, din, read_req,
      output dout, dout_valid, empty, full, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/ram_fifo_controller.sv
// Synchronous FIFO built on a dual-port RAM with one-cycle read latency.
// Pointers carry an extra wrap bit; all flags and count are registered.
module dual_port_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] dout
);
   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (write_en) r_mem[waddr] <= din;
      if (read_en)  dout         <= r_mem[raddr];
   end
endmodule

module ram_fifo_controller #(
   parameter int ADDR_WIDTH        = 8,
   parameter int DATA_WIDTH        = 32,
   parameter int ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 4
) (
   input logic                    clk,
   input logic                    reset_n,
   ram_fifo_controller_if.slave   bus
);
   localparam logic [ADDR_WIDTH:0] AF_LEVEL = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   w_wr_nxt;
   logic [ADDR_WIDTH:0]   w_rd_nxt;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_almost_full;
   logic                  r_vld_p1;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic [DATA_WIDTH-1:0] w_rdata_p1;

   // Acceptance uses the registered flags, so a full FIFO never writes the slot being read.
   always_comb begin
      w_push_ok = bus.write_req & ~r_full  & ~bus.sync_clear;
      w_pop_ok  = bus.read_req  & ~r_empty & ~bus.sync_clear;
      w_wr_nxt  = r_wr_ptr;
      w_rd_nxt  = r_rd_ptr;
      if (bus.sync_clear) begin
         w_wr_nxt = '0;
         w_rd_nxt = '0;
      end else begin
         if (w_push_ok) w_wr_nxt = r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  w_rd_nxt = r_rd_ptr + PTR_ONE;
      end
      w_count_nxt = w_wr_nxt - w_rd_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_empty       <= 1'b1;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_vld_p1      <= 1'b0;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         r_wr_ptr      <= w_wr_nxt;
         r_rd_ptr      <= w_rd_nxt;
         r_count       <= w_count_nxt;
         r_empty       <= (w_wr_nxt == w_rd_nxt);
         r_full        <= (w_wr_nxt[ADDR_WIDTH-1:0] == w_rd_nxt[ADDR_WIDTH-1:0]) &&
                          (w_wr_nxt[ADDR_WIDTH] != w_rd_nxt[ADDR_WIDTH]);
         r_almost_full <= (w_count_nxt >= AF_LEVEL);
         r_vld_p1      <= w_pop_ok;
         r_overflow    <= bus.write_req & r_full  & ~bus.sync_clear;
         r_underflow   <= bus.read_req  & r_empty & ~bus.sync_clear;
      end
   end

   // Storage stage: data for a pop accepted this cycle lands on dout next cycle.
   dual_port_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk      (clk),
      .write_en (w_push_ok),
      .waddr    (r_wr_ptr[ADDR_WIDTH-1:0]),
      .din      (bus.din),
      .read_en  (w_pop_ok),
      .raddr    (r_rd_ptr[ADDR_WIDTH-1:0]),
      .dout     (w_rdata_p1)
   );

   assign bus.dout        = w_rdata_p1;
   assign bus.dout_valid  = r_vld_p1;
   assign bus.empty       = r_empty;
   assign bus.full        = r_full;
   assign bus.almost_full = r_almost_full;
   assign bus.count       = r_count;
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;
endmodule
